// File: rtl/disp_pkg.sv
// Mode geometry for the display timing generator: per-mode porch/sync widths and polarity.
package disp_pkg;

    localparam int TW = 11;

    typedef enum logic [1:0] {
        VGA  = 2'd0,
        XGA  = 2'd1,
        SVGA = 2'd2,
        SXGA = 2'd3
    } mode_t;

    typedef struct packed {
        logic [TW-1:0] hact;
        logic [TW-1:0] hfp;
        logic [TW-1:0] hsw;
        logic [TW-1:0] hbp;
        logic [TW-1:0] vact;
        logic [TW-1:0] vfp;
        logic [TW-1:0] vsw;
        logic [TW-1:0] vbp;
        logic          pol;   // asserted sync level
    } timing_t;

    typedef struct packed {
        logic [TW-1:0] htot;
        logic [TW-1:0] vtot;
    } totals_t;

    localparam timing_t TIMING [4] = '{
        '{11'd640,  11'd16, 11'd96,  11'd48,  11'd480,  11'd10, 11'd2, 11'd33, 1'b0},
        '{11'd1024, 11'd24, 11'd136, 11'd160, 11'd768,  11'd3,  11'd6, 11'd29, 1'b0},
        '{11'd800,  11'd40, 11'd128, 11'd88,  11'd600,  11'd1,  11'd4, 11'd23, 1'b1},
        '{11'd1280, 11'd48, 11'd112, 11'd248, 11'd1024, 11'd1,  11'd3, 11'd38, 1'b1}
    };

    function automatic totals_t mode_totals(input mode_t m);
        totals_t t;
        t.htot = TIMING[m].hact + TIMING[m].hfp + TIMING[m].hsw + TIMING[m].hbp;
        t.vtot = TIMING[m].vact + TIMING[m].vfp + TIMING[m].vsw + TIMING[m].vbp;
        return t;
    endfunction

endpackage

// File: rtl/disp_sel_sync.sv
// Generic N-stage synchronizer for a bit vector arriving asynchronously to clk.
module disp_sel_sync #(
    parameter int W = 2,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [N-1:0][W-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[N-2:0], d_i};
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/disp_syncgen.sv
// Display timing generator: pixel/line counters for the active mode, registered sync, DE and coordinates.
module disp_syncgen
    import disp_pkg::*;
#(
    parameter int CW          = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic          dclk,
    input  logic          rst,
    input  logic [1:0]    clk_sel,
    output logic          dsp_hsync,
    output logic          dsp_vsync,
    output logic          dsp_de,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          frame_start,
    output logic [1:0]    mode
);

    logic [1:0]    sel_s;
    mode_t         mode_q, mode_d, mode_out_q;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    totals_t       tot;
    logic [CW-1:0] hact, hs_beg, hs_end, vact, vs_beg, vs_end;
    logic          pol, line_end, frame_end;
    logic          de_d, hsync_d, vsync_d, fs_d;
    logic [CW-1:0] hcnt_d, vcnt_d;
    logic          de_q, hsync_q, vsync_q, fs_q;
    logic [CW-1:0] hcnt_q, vcnt_q;

    disp_sel_sync #(
        .W (2),
        .N (SYNC_STAGES)
    ) u_sel_sync (
        .clk  (dclk),
        .srst (rst),
        .d_i  (clk_sel),
        .q_o  (sel_s)
    );

    always_comb begin
        tot    = mode_totals(mode_q);
        pol    = TIMING[mode_q].pol;
        hact   = CW'(TIMING[mode_q].hact);
        hs_beg = CW'(TIMING[mode_q].hact + TIMING[mode_q].hfp);
        hs_end = CW'(TIMING[mode_q].hact + TIMING[mode_q].hfp + TIMING[mode_q].hsw);
        vact   = CW'(TIMING[mode_q].vact);
        vs_beg = CW'(TIMING[mode_q].vact + TIMING[mode_q].vfp);
        vs_end = CW'(TIMING[mode_q].vact + TIMING[mode_q].vfp + TIMING[mode_q].vsw);
    end

    always_comb begin
        line_end  = (hc_q == CW'(tot.htot - 1'b1));
        frame_end = line_end && (vc_q == CW'(tot.vtot - 1'b1));
        hc_d      = line_end ? '0 : hc_q + 1'b1;
        vc_d      = vc_q;
        mode_d    = mode_q;
        if (line_end) begin
            vc_d = frame_end ? '0 : vc_q + 1'b1;
        end
        // The new geometry lands with the wrap to (0,0), so a frame never mixes two modes.
        if (frame_end) begin
            mode_d = mode_t'(sel_s);
        end
    end

    always_comb begin
        de_d    = (hc_q < hact) && (vc_q < vact);
        hsync_d = ((hc_q >= hs_beg) && (hc_q < hs_end)) ? pol : ~pol;
        vsync_d = ((vc_q >= vs_beg) && (vc_q < vs_end)) ? pol : ~pol;
        hcnt_d  = de_d ? hc_q : '0;
        vcnt_d  = de_d ? vc_q : '0;
        fs_d    = (hc_q == '0) && (vc_q == '0);
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            hc_q       <= '0;
            vc_q       <= '0;
            mode_q     <= VGA;
            mode_out_q <= VGA;
            de_q       <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            fs_q       <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            mode_q     <= mode_d;
            mode_out_q <= mode_q;
            de_q       <= de_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            fs_q       <= fs_d;
        end
    end

    assign dsp_hsync   = hsync_q;
    assign dsp_vsync   = vsync_q;
    assign dsp_de      = de_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign frame_start = fs_q;
    assign mode        = mode_out_q;

endmodule

// File: tb/tb_disp_syncgen.sv
// Bench for disp_syncgen: frame-position reference model plus spot checks of mode switching and reset.
module tb_disp_syncgen;

    localparam int CW = 11;
    localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 26'd0};

    logic          dclk    = 1'b0;
    logic          rst     = 1'b1;
    logic [1:0]    clk_sel = 2'b00;
    logic          dsp_hsync, dsp_vsync, dsp_de, frame_start;
    logic [CW-1:0] hcnt, vcnt;
    logic [1:0]    mode;
    logic [27:0]   dut_vec;
    logic [27:0]   exp_vec;

    int cmp_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    int fs_cyc0 = 0;

    // Mode table in clk_sel order: VGA, XGA, SVGA, SXGA
    int   HACT [4] = '{640, 1024, 800, 1280};
    int   HFP  [4] = '{16, 24, 40, 48};
    int   HSW  [4] = '{96, 136, 128, 112};
    int   HBP  [4] = '{48, 160, 88, 248};
    int   VACT [4] = '{480, 768, 600, 1024};
    int   VFP  [4] = '{10, 3, 1, 1};
    int   VSW  [4] = '{2, 6, 4, 3};
    int   VBP  [4] = '{33, 29, 23, 38};
    logic POL  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Model: linear position inside the current frame plus the last two clk_sel samples.
    int         m_mode = 0;
    int         m_p    = 0;
    logic [1:0] m_h0   = 2'b00;
    logic [1:0] m_h1   = 2'b00;

    disp_syncgen #(
        .CW          (CW),
        .SYNC_STAGES (2)
    ) dut (
        .dclk        (dclk),
        .rst         (rst),
        .clk_sel     (clk_sel),
        .dsp_hsync   (dsp_hsync),
        .dsp_vsync   (dsp_vsync),
        .dsp_de      (dsp_de),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .frame_start (frame_start),
        .mode        (mode)
    );

    always #5 dclk = ~dclk;

    assign dut_vec = {dsp_hsync, dsp_vsync, dsp_de, hcnt, vcnt, frame_start, mode};

    task automatic tick();
        int   ht, vt, x, y;
        logic de, hs, vs;
        @(posedge dclk);
        if (rst) begin
            exp_vec = RST_VEC;
            m_mode  = 0;
            m_p     = 0;
            m_h0    = 2'b00;
            m_h1    = 2'b00;
        end else begin
            ht = HACT[m_mode] + HFP[m_mode] + HSW[m_mode] + HBP[m_mode];
            vt = VACT[m_mode] + VFP[m_mode] + VSW[m_mode] + VBP[m_mode];
            x  = m_p % ht;
            y  = m_p / ht;
            de = (x < HACT[m_mode]) && (y < VACT[m_mode]);
            hs = (x >= HACT[m_mode] + HFP[m_mode] && x < HACT[m_mode] + HFP[m_mode] + HSW[m_mode])
                 ? POL[m_mode] : ~POL[m_mode];
            vs = (y >= VACT[m_mode] + VFP[m_mode] && y < VACT[m_mode] + VFP[m_mode] + VSW[m_mode])
                 ? POL[m_mode] : ~POL[m_mode];
            exp_vec = {hs, vs, de, de ? 11'(x) : 11'd0, de ? 11'(y) : 11'd0,
                       (x == 0) && (y == 0), 2'(m_mode)};
            if (m_p == ht * vt - 1) begin
                m_p    = 0;
                m_mode = int'(m_h1);
            end else begin
                m_p++;
            end
            m_h1 = m_h0;
            m_h0 = clk_sel;
        end
        cyc++;
        @(negedge dclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clk_sel = 2'($urandom_range(0, 3));
            tick();
            cmp_cnt++;
            if (dut_vec !== RST_VEC) begin
                fail_cnt++;
                $display("FAIL reset_state: got %h expected %h at cycle %0d", dut_vec, RST_VEC, cyc);
            end
        end
        clk_sel = 2'b00;
        rst     = 1'b0;
    endtask

    task automatic test_vga_frame();
        int errs = 0, de_cnt = 0, hs_lo = 0, hs_first = -1, vs_lo = 0, vs_first = -1, fs_extra = 0;
        int glitch_k, sw_k;
        int last_k = 479 * 800 + 639;
        glitch_k = $urandom_range(10, 150) * 800 + $urandom_range(0, 399);
        sw_k     = 200 * 800 + $urandom_range(0, 799);
        for (int k = 0; k < 420000; k++) begin
            tick();
            if (errs < 5) begin
                cmp_cnt++;
                if (dut_vec !== exp_vec) begin
                    errs++;
                    fail_cnt++;
                    $display("FAIL vga_model: got %h expected %h at cycle %0d", dut_vec, exp_vec, cyc);
                end
            end
            if (k == 0) begin
                fs_cyc0 = cyc;
                cmp_cnt++;
                if ({frame_start, mode} !== 3'b1_00) begin
                    fail_cnt++;
                    $display("FAIL first_frame_start: got fs=%b mode=%b expected fs=1 mode=00", frame_start, mode);
                end
            end
            if (k > 0 && frame_start) fs_extra++;
            if (k < 800 && !dsp_hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_lo++;
            end
            if (!dsp_vsync) begin
                if (vs_first < 0) vs_first = k;
                vs_lo++;
            end
            de_cnt += int'(dsp_de);
            if (k == last_k) begin
                cmp_cnt++;
                if ({dsp_de, hcnt, vcnt} !== {1'b1, 11'd639, 11'd479}) begin
                    fail_cnt++;
                    $display("FAIL last_active: got de=%b x=%0d y=%0d expected de=1 x=639 y=479", dsp_de, hcnt, vcnt);
                end
            end
            if (k == last_k + 1) begin
                cmp_cnt++;
                if ({dsp_de, hcnt, vcnt} !== 23'd0) begin
                    fail_cnt++;
                    $display("FAIL after_active: got de=%b x=%0d y=%0d expected de=0 x=0 y=0", dsp_de, hcnt, vcnt);
                end
            end
            if (k == glitch_k)       clk_sel = 2'b01;
            if (k == glitch_k + 400) clk_sel = 2'b00;
            if (k == sw_k)           clk_sel = 2'b10;
        end
        cmp_cnt++;
        if (de_cnt != 307200) begin
            fail_cnt++;
            $display("FAIL vga_de_count: got %0d expected 307200", de_cnt);
        end
        cmp_cnt++;
        if (hs_first != 656 || hs_lo != 96) begin
            fail_cnt++;
            $display("FAIL vga_hsync_window: got start %0d len %0d expected start 656 len 96", hs_first, hs_lo);
        end
        cmp_cnt++;
        if (vs_first != 490 * 800 || vs_lo != 1600) begin
            fail_cnt++;
            $display("FAIL vga_vsync_window: got start %0d len %0d expected start 392000 len 1600", vs_first, vs_lo);
        end
        cmp_cnt++;
        if (fs_extra != 0) begin
            fail_cnt++;
            $display("FAIL vga_extra_fs: got %0d extra pulses expected 0", fs_extra);
        end
    endtask

    task automatic test_mode_switch();
        int errs = 0, de_cnt = 0, hs_hi = 0, hs_first = -1;
        int stop_k = 300 * 1056 + 499;
        for (int k = 0; k <= stop_k; k++) begin
            tick();
            if (errs < 5) begin
                cmp_cnt++;
                if (dut_vec !== exp_vec) begin
                    errs++;
                    fail_cnt++;
                    $display("FAIL svga_model: got %h expected %h at cycle %0d", dut_vec, exp_vec, cyc);
                end
            end
            if (k == 0) begin
                cmp_cnt++;
                if ({frame_start, mode} !== 3'b1_10 || cyc - fs_cyc0 != 420000) begin
                    fail_cnt++;
                    $display("FAIL svga_frame_start: got fs=%b mode=%b period %0d expected fs=1 mode=10 period 420000",
                             frame_start, mode, cyc - fs_cyc0);
                end
            end
            if (k < 1056) begin
                de_cnt += int'(dsp_de);
                if (dsp_hsync) begin
                    if (hs_first < 0) hs_first = k;
                    hs_hi++;
                end
            end
        end
        cmp_cnt++;
        if (de_cnt != 800) begin
            fail_cnt++;
            $display("FAIL svga_de_width: got %0d expected 800", de_cnt);
        end
        cmp_cnt++;
        if (hs_first != 840 || hs_hi != 128) begin
            fail_cnt++;
            $display("FAIL svga_hsync_window: got start %0d len %0d expected start 840 len 128", hs_first, hs_hi);
        end
    endtask

    task automatic test_reset_midframe();
        rst     = 1'b1;
        clk_sel = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp_cnt++;
            if (dut_vec !== RST_VEC || dut_vec !== exp_vec) begin
                fail_cnt++;
                $display("FAIL midframe_reset: got %h expected %h at cycle %0d", dut_vec, RST_VEC, cyc);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sxga_after_reset();
        int errs = 0, bad_mode = 0, de_cnt = 0, hs_hi = 0, hs_first = -1, hs_first2 = -1;
        int f1 = 420000;
        for (int k = 0; k < f1 + 2 * 1688; k++) begin
            tick();
            if (errs < 5) begin
                cmp_cnt++;
                if (dut_vec !== exp_vec) begin
                    errs++;
                    fail_cnt++;
                    $display("FAIL sxga_model: got %h expected %h at cycle %0d", dut_vec, exp_vec, cyc);
                end
            end
            if (k == 0) begin
                cmp_cnt++;
                if ({frame_start, dsp_de, hcnt, vcnt, mode} !== {1'b1, 1'b1, 22'd0, 2'b00}) begin
                    fail_cnt++;
                    $display("FAIL restart_frame_start: got fs=%b de=%b x=%0d y=%0d mode=%b expected 1 1 0 0 00",
                             frame_start, dsp_de, hcnt, vcnt, mode);
                end
            end
            if (k < f1 && mode !== 2'b00) bad_mode++;
            if (k == f1) begin
                cmp_cnt++;
                if ({frame_start, mode} !== 3'b1_11) begin
                    fail_cnt++;
                    $display("FAIL sxga_frame_start: got fs=%b mode=%b expected fs=1 mode=11", frame_start, mode);
                end
            end
            if (k >= f1 && k < f1 + 1688) begin
                de_cnt += int'(dsp_de);
                if (dsp_hsync) begin
                    if (hs_first < 0) hs_first = k - f1;
                    hs_hi++;
                end
            end
            if (k >= f1 + 1688 && dsp_hsync && hs_first2 < 0) hs_first2 = k - f1;
        end
        cmp_cnt++;
        if (bad_mode != 0) begin
            fail_cnt++;
            $display("FAIL vga_mode_held: got %0d non-VGA cycles expected 0", bad_mode);
        end
        cmp_cnt++;
        if (de_cnt != 1280) begin
            fail_cnt++;
            $display("FAIL sxga_de_width: got %0d expected 1280", de_cnt);
        end
        cmp_cnt++;
        if (hs_first != 1328 || hs_hi != 112) begin
            fail_cnt++;
            $display("FAIL sxga_hsync_window: got start %0d len %0d expected start 1328 len 112", hs_first, hs_hi);
        end
        cmp_cnt++;
        if (hs_first2 != 1688 + 1328) begin
            fail_cnt++;
            $display("FAIL sxga_line_length: got second hsync at %0d expected 3016", hs_first2);
        end
    endtask

    initial begin
        test_reset();
        test_vga_frame();
        test_mode_switch();
        test_reset_midframe();
        test_sxga_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
